// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM states, ACK levels and
// the oversampling-ratio check used at elaboration.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } i2c_slv_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // Sync + glitch filter eat several clocks per edge; below this the
   // filtered SCL phases get too short to be usable.
   localparam int MIN_OVERSAMPLE = 20;

   function automatic bit ratio_ok(input int clk_freq, input int i2c_freq);
      return (i2c_freq > 0) && ((clk_freq / i2c_freq) >= MIN_OVERSAMPLE);
   endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// User-side handshake of the I2C target: received bytes, transmit fetch and
// transfer status.
interface i2c_slave_if;
   logic       msb_lsb;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       rw;
   logic       busy;
   logic       nack_seen;

   modport slave (
      input  msb_lsb, tx_data,
      output rx_data, rx_valid, tx_req, rw, busy, nack_seen
   );

   modport master (
      output msb_lsb, tx_data,
      input  rx_data, rx_valid, tx_req, rw, busy, nack_seen
   );
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one bus line;
// emits single-clk rise/fall pulses aligned with the filtered value change.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic arstn,
   input  logic din,
   output logic filt,
   output logic rise,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // cnt tracks how many consecutive synced samples disagree with filt;
   // any agreeing sample restarts the run.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         sync <= 2'b11;
         filt <= 1'b1;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            filt <= sync[1];
            cnt  <= '0;
            rise <= sync[1];
            fall <= ~sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_slave.sv
// I2C target without clock stretching: filtered SCL/SDA, START/STOP detect,
// 7-bit address match, byte delivery to and fetch from user logic.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         CLK_FREQ   = 100_000_000,
   parameter int         I2C_FREQ   = 100_000,
   parameter int         FILTER_LEN = 3
) (
   input  logic        clk,
   input  logic        arstn,
   input  logic        scl,
   inout  wire         sda,
   i2c_slave_if.slave  usr
);

   if (!ratio_ok(CLK_FREQ, I2C_FREQ)) begin : g_bad_ratio
      $fatal(1, "i2c_slave: CLK_FREQ/I2C_FREQ must be at least 20");
   end

   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk(clk), .arstn(arstn), .din(scl),
      .filt(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk(clk), .arstn(arstn), .din(sda),
      .filt(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;

   i2c_slv_state_t state, state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shreg, shreg_n;
   logic [7:0] tx_byte, tx_byte_n;
   logic [1:0] ld_cnt, ld_cnt_n;
   logic       phase, phase_n;
   logic       sda_low, sda_low_n;
   logic       busy_r, busy_n;
   logic       rw_r, rw_n;
   logic [7:0] rx_data_r, rx_data_n;
   logic       rx_valid_r, rx_valid_n;
   logic       tx_req_r, tx_req_n;
   logic       nack_r, nack_n;
   logic [7:0] addr_shift, wr_shift;

   assign sda = sda_low ? 1'b0 : 1'bz;

   assign usr.rx_data   = rx_data_r;
   assign usr.rx_valid  = rx_valid_r;
   assign usr.tx_req    = tx_req_r;
   assign usr.rw        = rw_r;
   assign usr.busy      = busy_r;
   assign usr.nack_seen = nack_r;

   assign addr_shift = {shreg[6:0], sda_f};
   assign wr_shift   = usr.msb_lsb ? {shreg[6:0], sda_f} : {sda_f, shreg[7:1]};

   // bit_cnt counts 7..0 over a byte; map it to the byte bit on the wire.
   function automatic logic sel_bit(input logic [7:0] b, input logic [2:0] idx,
                                    input logic msb);
      return msb ? b[idx] : b[3'd7 - idx];
   endfunction

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         tx_byte    <= '0;
         ld_cnt     <= '0;
         phase      <= 1'b0;
         sda_low    <= 1'b0;
         busy_r     <= 1'b0;
         rw_r       <= 1'b0;
         rx_data_r  <= '0;
         rx_valid_r <= 1'b0;
         tx_req_r   <= 1'b0;
         nack_r     <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         tx_byte    <= tx_byte_n;
         ld_cnt     <= ld_cnt_n;
         phase      <= phase_n;
         sda_low    <= sda_low_n;
         busy_r     <= busy_n;
         rw_r       <= rw_n;
         rx_data_r  <= rx_data_n;
         rx_valid_r <= rx_valid_n;
         tx_req_r   <= tx_req_n;
         nack_r     <= nack_n;
      end
   end

   // phase splits each ACK slot into "drive on first fall" / "leave on second
   // fall"; in RD_ACK it marks that the master ACKed and a byte is due.
   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      tx_byte_n  = tx_byte;
      ld_cnt_n   = (ld_cnt != 2'd0) ? ld_cnt - 2'd1 : 2'd0;
      phase_n    = phase;
      sda_low_n  = sda_low;
      busy_n     = busy_r;
      rw_n       = rw_r;
      rx_data_n  = rx_data_r;
      rx_valid_n = 1'b0;
      tx_req_n   = 1'b0;
      nack_n     = 1'b0;

      if (ld_cnt == 2'd1) tx_byte_n = usr.tx_data;

      if (stop_det) begin
         state_n   = IDLE;
         sda_low_n = 1'b0;
         busy_n    = 1'b0;
         phase_n   = 1'b0;
         ld_cnt_n  = 2'd0;
      end else if (start_det) begin
         state_n   = ADDR;
         bit_cnt_n = 3'd7;
         sda_low_n = 1'b0;
         busy_n    = 1'b0;
         phase_n   = 1'b0;
         ld_cnt_n  = 2'd0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               shreg_n = addr_shift;
               if (bit_cnt == 3'd0) begin
                  if (addr_shift[7:1] == SLAVE_ADDR) begin
                     rw_n    = addr_shift[0];
                     state_n = ADDR_ACK;
                  end else begin
                     state_n = IGNORE;
                  end
               end else begin
                  bit_cnt_n = bit_cnt - 3'd1;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               if (!phase) begin
                  sda_low_n = 1'b1;
                  busy_n    = 1'b1;
                  phase_n   = 1'b1;
                  if (rw_r) begin
                     tx_req_n = 1'b1;
                     ld_cnt_n = 2'd2;
                  end
               end else begin
                  phase_n   = 1'b0;
                  bit_cnt_n = 3'd7;
                  if (rw_r) begin
                     state_n   = RD_DATA;
                     sda_low_n = ~sel_bit(tx_byte, 3'd7, usr.msb_lsb);
                  end else begin
                     state_n   = WR_DATA;
                     sda_low_n = 1'b0;
                  end
               end
            end
            WR_DATA: if (scl_rise) begin
               shreg_n = wr_shift;
               if (bit_cnt == 3'd0) begin
                  rx_data_n  = wr_shift;
                  rx_valid_n = 1'b1;
                  phase_n    = 1'b0;
                  state_n    = WR_ACK;
               end else begin
                  bit_cnt_n = bit_cnt - 3'd1;
               end
            end
            WR_ACK: if (scl_fall) begin
               if (!phase) begin
                  sda_low_n = 1'b1;
                  phase_n   = 1'b1;
               end else begin
                  sda_low_n = 1'b0;
                  phase_n   = 1'b0;
                  bit_cnt_n = 3'd7;
                  state_n   = WR_DATA;
               end
            end
            RD_DATA: if (scl_fall) begin
               if (bit_cnt == 3'd0) begin
                  sda_low_n = 1'b0;
                  phase_n   = 1'b0;
                  state_n   = RD_ACK;
               end else begin
                  bit_cnt_n = bit_cnt - 3'd1;
                  sda_low_n = ~sel_bit(tx_byte, bit_cnt - 3'd1, usr.msb_lsb);
               end
            end
            RD_ACK: begin
               if (!phase) begin
                  if (scl_rise) begin
                     if (sda_f == I2C_ACK) begin
                        tx_req_n = 1'b1;
                        phase_n  = 1'b1;
                     end else begin
                        nack_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IGNORE;
                     end
                  end
               end else if (scl_fall) begin
                  tx_byte_n = usr.tx_data;
                  sda_low_n = ~sel_bit(usr.tx_data, 3'd7, usr.msb_lsb);
                  bit_cnt_n = 3'd7;
                  phase_n   = 1'b0;
                  state_n   = RD_DATA;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
